// File: rtl/isa_shared_pkg.sv
// isa_shared: sequencer state, trap cause encodings and decoder no-op codes
package isa_shared;
  typedef enum logic [2:0] {S_FETCH, S_DECODE, S_EXEC, S_MEM, S_WB, S_TRAP} seq_state_t;
  typedef enum logic [1:0] {TC_NONE, TC_ILLEGAL, TC_CONFLICT, TC_TIMEOUT} trap_cause_t;
  localparam logic [2:0] ALU_NOP = 3'd0;
  localparam logic [2:0] IMM_NOP = 3'd0;
  function automatic logic is_wait_state(seq_state_t s);
    return s == S_FETCH || s == S_MEM;
  endfunction
endpackage

// File: rtl/ack_timer.sv
// ack_timer: counts consecutive waiting cycles, expired flags the last allowed one
module ack_timer #(
  parameter int LIMIT = 16
) (
  input  logic clk,
  input  logic rst,
  input  logic clear,
  input  logic count,
  output logic expired
);
  localparam int W = LIMIT > 1 ? $clog2(LIMIT) : 1;
  logic [W-1:0] cnt;
  assign expired = cnt == W'(LIMIT - 1);
  always_ff @(posedge clk)
    if (rst || clear) cnt <= '0;
    else if (count && !expired) cnt <= cnt + 1'b1;
endmodule

// File: rtl/core_sequencer.sv
// core_sequencer: multi-cycle fetch/decode/execute/memory/writeback control with fault trapping
module core_sequencer
  import isa_shared::*;
#(
  parameter int DATA_WIDTH  = 32,
  parameter int ACK_TIMEOUT = 16
) (
  input  logic                  clk,
  input  logic                  rst,
  output logic                  imem_req,
  output logic [DATA_WIDTH-1:0] imem_addr,
  input  logic                  imem_ack,
  input  logic [DATA_WIDTH-1:0] imem_rdata,
  output logic [DATA_WIDTH-1:0] instr,
  input  logic [2:0]            alu_op,
  input  logic [2:0]            imm_op,
  input  logic                  mem_read,
  input  logic                  mem_write,
  input  logic                  reg_write,
  output logic                  alu_en,
  output logic                  dmem_req,
  output logic                  dmem_we,
  input  logic                  dmem_ack,
  output logic                  rf_we,
  output logic [DATA_WIDTH-1:0] pc,
  output logic [DATA_WIDTH-1:0] instret,
  output logic                  trap,
  output logic [1:0]            trap_cause
);
  seq_state_t  state, next_state;
  trap_cause_t cause, next_cause;
  logic waiting, ack, expired, retire;
  assign waiting = is_wait_state(state);
  assign ack = (state == S_FETCH && imem_ack) || (state == S_MEM && dmem_ack);
  // an ack on the expiring cycle clears the timer instead of trapping
  ack_timer #(.LIMIT(ACK_TIMEOUT)) u_timer (
    .clk(clk),
    .rst(rst),
    .clear(!waiting || ack),
    .count(waiting && !ack),
    .expired(expired)
  );
  assign imem_req   = state == S_FETCH;
  assign imem_addr  = pc;
  assign alu_en     = state == S_EXEC;
  assign dmem_req   = state == S_MEM;
  assign dmem_we    = dmem_req && mem_write;
  assign rf_we      = state == S_WB;
  assign trap       = state == S_TRAP;
  assign trap_cause = cause;
  always_comb begin
    next_state = state;
    next_cause = cause;
    retire     = 1'b0;
    case (state)
      S_FETCH: begin
        next_state = imem_ack ? S_DECODE : expired ? S_TRAP : S_FETCH;
        next_cause = !imem_ack && expired ? TC_TIMEOUT : cause;
      end
      S_DECODE: begin
        next_state = (alu_op == ALU_NOP && imm_op == IMM_NOP) || (mem_read && mem_write) ? S_TRAP : S_EXEC;
        next_cause = alu_op == ALU_NOP && imm_op == IMM_NOP ? TC_ILLEGAL :
                     mem_read && mem_write ? TC_CONFLICT : cause;
      end
      S_EXEC: begin
        next_state = mem_read || mem_write ? S_MEM : reg_write ? S_WB : S_FETCH;
        retire     = !(mem_read || mem_write || reg_write);
      end
      S_MEM: begin
        next_state = dmem_ack ? (mem_read ? S_WB : S_FETCH) : expired ? S_TRAP : S_MEM;
        next_cause = !dmem_ack && expired ? TC_TIMEOUT : cause;
        retire     = dmem_ack && !mem_read;
      end
      S_WB: begin
        next_state = S_FETCH;
        retire     = 1'b1;
      end
      S_TRAP: next_state = S_TRAP;
      default: next_state = S_FETCH;
    endcase
  end
  always_ff @(posedge clk)
    if (rst) begin
      state   <= S_FETCH;
      cause   <= TC_NONE;
      pc      <= '0;
      instr   <= '0;
      instret <= '0;
    end else begin
      state <= next_state;
      cause <= next_cause;
      if (state == S_FETCH && imem_ack) instr <= imem_rdata;
      if (retire) begin
        pc      <= pc + DATA_WIDTH'(4);
        instret <= instret + DATA_WIDTH'(1);
      end
    end
endmodule

// File: doc/core_sequencer.md
CORE_SEQUENCER -- requirements
Module: core_sequencer

Interface
REQ-001 SHALL have parameter DATA_WIDTH, default 32, meaning instruction, address and data width.
REQ-002 SHALL have parameter ACK_TIMEOUT, default 16, meaning maximum wait cycles for a memory acknowledge.
REQ-003 SHALL have one clock and a synchronous, active-high reset: clk  input  1  rising-edge clock; rst  input  1  synchronous active-high reset.
REQ-004 SHALL have these ports, one per line:
- imem_req  output  1  instruction fetch request, held until acknowledged.
- imem_addr  output  DATA_WIDTH  fetch address, equal to pc.
- imem_ack  input  1  fetch complete; imem_rdata valid this cycle.
- imem_rdata  input  DATA_WIDTH  fetched instruction.
- instr  output  DATA_WIDTH  latched instruction register, drives the decoder.
- alu_op  input  3  decoder ALU operation.
- imm_op  input  3  decoder immediate select.
- mem_read  input  1  decoder load flag.
- mem_write  input  1  decoder store flag.
- reg_write  input  1  decoder register-write flag.
- alu_en  output  1  one-cycle execute strobe.
- dmem_req  output  1  data request, held until acknowledged.
- dmem_we  output  1  data request is a write; valid while dmem_req is high.
- dmem_ack  input  1  data access complete.
- rf_we  output  1  one-cycle register-file write strobe.
- pc  output  DATA_WIDTH  program counter.
- instret  output  DATA_WIDTH  retired-instruction count.
- trap  output  1  sticky fault indicator.
- trap_cause  output  2  fault reason, trap_cause_t.

Function
REQ-005 SHALL sequence the states FETCH, DECODE, EXEC, MEM, WB and TRAP, with one state active per cycle.
REQ-006 FETCH: SHALL drive imem_req=1 until imem_ack=1; on the ack cycle, SHALL load instr from imem_rdata and enter DECODE on the next edge.
REQ-007 DECODE: one cycle; if alu_op==ALU_NOP and imm_op==ALU_NOP's counterpart IMM_NOP, SHALL enter TRAP with cause ILLEGAL.
REQ-008 DECODE: if mem_read and mem_write are both 1, SHALL enter TRAP with cause CONFLICT; otherwise SHALL enter EXEC.
REQ-009 EXEC: SHALL pulse alu_en for exactly one cycle.
REQ-010 EXEC: next state SHALL be MEM if mem_read|mem_write, else WB if reg_write, else FETCH with retire.
REQ-011 MEM: SHALL hold dmem_req=1 and dmem_we=mem_write until dmem_ack=1.
REQ-012 MEM: on dmem_ack, next state SHALL be WB if mem_read, else FETCH with retire.
REQ-013 WB: SHALL pulse rf_we for one cycle, then retire and enter FETCH.
REQ-014 Retire SHALL set pc to pc+4 modulo 2^DATA_WIDTH and instret to instret+1, wrapping silently.
REQ-015 Minimum latency SHALL be: ALU-only instruction 3 cycles with zero-wait ack; lw 5 cycles.
REQ-016 Wait counter SHALL clear on entry to FETCH and MEM and increment each waiting cycle.
REQ-017 On reaching ACK_TIMEOUT without an ack, SHALL enter TRAP with cause TIMEOUT; an ack in the same cycle SHALL win.
REQ-018 imem_ack outside FETCH and dmem_ack outside MEM SHALL be ignored.
REQ-019 TRAP SHALL hold trap=1, keep all request and strobe outputs 0, and freeze pc, instr and instret until rst.

Reset
REQ-020 rst SHALL override every state on the next edge.
REQ-021 After reset: state=FETCH, pc=0, instr=0, instret=0, trap=0, trap_cause=NONE, wait counter=0.
REQ-022 After reset: alu_en=0, rf_we=0, dmem_req=0 and dmem_we=0.
REQ-023 imem_req SHALL assert in the first cycle after rst deasserts.
REQ-024 Reset during a pending MEM access SHALL drop dmem_req the next cycle without retiring.

Structure
REQ-025 seq_state_t and trap_cause_t (NONE, ILLEGAL, CONFLICT, TIMEOUT) SHALL live in isa_shared, alongside ALU_NOP and IMM_NOP.
REQ-026 The wait counter SHALL be a sub-module ack_timer with ports clk, rst, clear, count and expired.
REQ-027 The decoder SHALL be instantiated outside core_sequencer and fed by instr.

Verification
REQ-028 Bench SHALL cover: lw x5,0(x1) (0x0000A283), zero-wait acks -> states F,D,E,M,W; dmem_we=0; rf_we one cycle; pc=4; instret=1.
REQ-029 Bench SHALL cover: imem_ack delayed 3 cycles -> imem_req high 4 cycles; instr latched only on the ack cycle.
REQ-030 Bench SHALL cover: instruction 0x00000013 (decoder NOP outputs) -> TRAP, trap_cause=ILLEGAL, pc frozen at its value.
REQ-031 Bench SHALL cover: dmem_ack withheld, ACK_TIMEOUT=4 -> trap asserts after 4 MEM cycles, cause TIMEOUT, dmem_req=0.
REQ-032 Bench SHALL cover: rst asserted mid-MEM -> next cycle state=FETCH, pc=0, dmem_req=0, imem_req=1 after release.
REQ-033 Bench SHALL cover: pc preloaded to 0xFFFFFFFC via forced retire -> pc wraps to 0x00000000.
